// File: rtl/haar_pkg.sv
// Shared types and constants for the Haar cascade sequencer and its classifier datapath.
package haar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    TREE,
    THR,
    EOD,
    DECIDE,
    DONE
  } state_e;

  localparam int NUM_CLASSIFIERS     = 18;
  localparam int NUM_STAGE_THRESHOLD = 3;
  localparam int HDR_CYCLES          = 2;
  localparam int THR_CYCLES          = 4;

  // Word positions inside one tree record.
  localparam int WEIGHT_1  = 4;
  localparam int THRESHOLD = 15;
  localparam int LEFT      = 16;
  localparam int RIGHT     = 17;

endpackage

// File: rtl/counter.sv
// Synchronous up-counter with clear priority over increment; active-low synchronous reset.
module counter #(
  parameter int WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/haar_cascade_sequencer.sv
// Sequences the classifier through every stage of a Haar cascade for one window:
// header fetch, tree word streaming, trailer fetch, stage verdict and early exit.
module haar_cascade_sequencer #(
  parameter int DATA_WIDTH_12       = 12,
  parameter int NUM_CLASSIFIERS     = 18,
  parameter int NUM_STAGE_THRESHOLD = 3,
  parameter int NUM_STAGES          = 22,
  parameter int MAX_TREES           = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [DATA_WIDTH_12-1:0] rom_addr,
  input  logic [DATA_WIDTH_12-1:0] rom_data,
  output logic [DATA_WIDTH_12-1:0] data,
  output logic                     en_copy,
  output logic [DATA_WIDTH_12-1:0] index_classifier,
  output logic                     calculate,
  output logic [DATA_WIDTH_12-1:0] index_tree,
  output logic                     end_single_classifier,
  output logic                     end_tree,
  output logic                     end_all_classifier,
  output logic                     end_database,
  input  logic                     candidate,
  output logic [DATA_WIDTH_12-1:0] stage_index,
  output logic                     busy,
  output logic                     done,
  output logic                     face
);
  import haar_pkg::*;

  localparam int W    = DATA_WIDTH_12;
  localparam int PH_W = $clog2(NUM_CLASSIFIERS + 2);

  localparam logic [PH_W-1:0] PH_LAST_ADDR = PH_W'(NUM_CLASSIFIERS - 1);
  localparam logic [PH_W-1:0] PH_LAST_WORD = PH_W'(NUM_CLASSIFIERS);
  localparam logic [PH_W-1:0] PH_CALC      = PH_W'(NUM_CLASSIFIERS + 1);
  localparam logic [PH_W-1:0] PH_HDR_LAST  = PH_W'(HDR_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_THR_LAST  = PH_W'(THR_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_THR_ISSUE = PH_W'(NUM_STAGE_THRESHOLD);
  localparam logic [W-1:0]    TREE_CLAMP   = W'(MAX_TREES);
  localparam logic [W-1:0]    STAGE_LAST   = W'(NUM_STAGES - 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [W-1:0]      rom_addr_q, rom_addr_d;
  logic [W-1:0]      tcount_q, tcount_d;
  logic [W-1:0]      stage_q, stage_d;
  logic              face_q, face_d;
  logic              en_copy_q, en_copy_d;
  logic              calc_q, calc_d;
  logic              end_single_q, end_single_d;
  logic              end_tree_q, end_tree_d;
  logic              end_all_q, end_all_d;
  logic              end_db_q, end_db_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              issue, tree_clr, tree_inc, word_clr, word_inc, last_tree;

  assign last_tree = (index_tree == tcount_q - W'(1));
  assign word_clr  = (state_q != TREE) || (phase_q == PH_CALC);
  assign word_inc  = (state_q == TREE) && (phase_q != '0) && (phase_q < PH_LAST_WORD);

  counter #(.WIDTH(W)) u_word_cnt (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (word_clr),
    .inc_i   (word_inc),
    .count_o (index_classifier)
  );

  counter #(.WIDTH(W)) u_tree_cnt (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (tree_clr),
    .inc_i   (tree_inc),
    .count_o (index_tree)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q + PH_W'(1);
    rom_addr_d = rom_addr_q;
    tcount_d   = tcount_q;
    stage_d    = stage_q;
    face_d     = face_q;
    issue      = 1'b0;
    tree_clr   = 1'b0;
    tree_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (start) begin
          state_d    = HDR;
          rom_addr_d = '0;
          stage_d    = '0;
          face_d     = 1'b0;
          tree_clr   = 1'b1;
        end
      end
      HDR: begin
        issue = (phase_q == '0);
        if (phase_q == PH_HDR_LAST) begin
          phase_d  = '0;
          tcount_d = (rom_data > TREE_CLAMP) ? TREE_CLAMP : rom_data;
          state_d  = (rom_data == '0) ? THR : TREE;
        end
      end
      TREE: begin
        issue = (phase_q <= PH_LAST_ADDR);
        if (phase_q == PH_CALC) begin
          phase_d  = '0;
          tree_inc = 1'b1;
          if (last_tree) state_d = THR;
        end
      end
      THR: begin
        issue = (phase_q < PH_THR_ISSUE);
        if (phase_q == PH_THR_LAST) begin
          phase_d = '0;
          state_d = EOD;
        end
      end
      EOD: begin
        phase_d = '0;
        state_d = DECIDE;
      end
      DECIDE: begin
        phase_d = '0;
        if (!candidate) begin
          face_d  = 1'b0;
          state_d = DONE;
        end else if (stage_q == STAGE_LAST) begin
          face_d  = 1'b1;
          state_d = DONE;
        end else begin
          stage_d  = stage_q + W'(1);
          tree_clr = 1'b1;
          state_d  = HDR;
        end
      end
      DONE: begin
        phase_d = '0;
        state_d = IDLE;
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase
    if (issue) rom_addr_d = rom_addr_q + W'(1);
  end

  // Strobes are decoded from the upcoming state/phase so they leave flops aligned to that cycle.
  always_comb begin
    en_copy_d    = (state_d == TREE) && (phase_d != '0) && (phase_d <= PH_LAST_WORD);
    end_single_d = (state_d == TREE) && (phase_d == PH_LAST_WORD);
    calc_d       = (state_d == TREE) && (phase_d == PH_CALC);
    end_tree_d   = calc_d && last_tree;
    end_all_d    = (state_d == THR) && (phase_d != '0);
    end_db_d     = (state_d == EOD);
    done_d       = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      rom_addr_q   <= '0;
      tcount_q     <= '0;
      stage_q      <= '0;
      face_q       <= 1'b0;
      en_copy_q    <= 1'b0;
      calc_q       <= 1'b0;
      end_single_q <= 1'b0;
      end_tree_q   <= 1'b0;
      end_all_q    <= 1'b0;
      end_db_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rom_addr_q   <= rom_addr_d;
      tcount_q     <= tcount_d;
      stage_q      <= stage_d;
      face_q       <= face_d;
      en_copy_q    <= en_copy_d;
      calc_q       <= calc_d;
      end_single_q <= end_single_d;
      end_tree_q   <= end_tree_d;
      end_all_q    <= end_all_d;
      end_db_q     <= end_db_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign rom_addr              = rom_addr_q;
  assign data                  = rom_data;
  assign en_copy               = en_copy_q;
  assign calculate             = calc_q;
  assign end_single_classifier = end_single_q;
  assign end_tree              = end_tree_q;
  assign end_all_classifier    = end_all_q;
  assign end_database          = end_db_q;
  assign stage_index           = stage_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign face                  = face_q;

endmodule

// File: doc/haar_cascade_sequencer.md
# haar_cascade_sequencer

Controller that sequences `fifo_stage_classifier` through a full Haar cascade for one detection window. It fetches tree and stage words from the classifier database ROM and drives the classifier's copy and calculate strobes. After each stage it samples `candidate` and either advances to the next stage or terminates early. The block sits between the window-ready logic (integral image buffered) and the classifier/database ROM pair.

## Interface
- `DATA_WIDTH_12`, 12, width of ROM words, addresses and indices
- `NUM_CLASSIFIERS`, 18, words per tree
- `NUM_STAGE_THRESHOLD`, 3, words per stage trailer (threshold, parent, next)
- `NUM_STAGES`, 22, stages in cascade
- `MAX_TREES`, 256, clamp for the per-stage tree count
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  reset is synchronous and active-low
- `start`  in  1  one-cycle pulse: integral image ready, evaluate window
- `rom_addr`  out  12  database ROM address (ROM read latency 1 cycle)
- `rom_data`  in  12  ROM word for address of previous cycle
- `data`  out  12  rom_data forwarded combinationally to classifier
- `en_copy`  out  1  classifier captures `data` into word `index_classifier`
- `index_classifier`  out  12  word index within tree, 0..17
- `calculate`  out  1  one-cycle pulse: evaluate loaded tree
- `index_tree`  out  12  tree index within current stage
- `end_single_classifier`  out  1  high with last word (index 17) of a tree
- `end_tree`  out  1  high with `calculate` of last tree of stage
- `end_all_classifier`  out  1  high while trailer words are on `data`
- `end_database`  out  1  one-cycle pulse: stage complete, classifier updates candidate
- `candidate`  in  1  classifier stage verdict, valid the cycle after `end_database`
- `stage_index`  out  12  current stage
- `busy`  out  1  high from cycle after start until done
- `done`  out  1  one-cycle pulse: window verdict on `face`
- `face`  out  1  1 = all stages passed; held until next start

## Operation
- States: IDLE, HDR, TREE, THR, EOD, DECIDE, DONE.
- IDLE: `start` → HDR. `rom_addr`, `stage_index` and `index_tree` are cleared to 0 and `face` to 0.
- Database layout per stage, contiguous: [tree_count][T×18 tree words][3 trailer words]. `rom_addr` increments by one per issued read and wraps mod 2^12.
- HDR, 2 cycles: issue header address, then capture tree_count T.
  - T > MAX_TREES: clamp to MAX_TREES.
  - T = 0: go to THR directly.
- TREE, 20 cycles per tree:
  - t0..t17: addresses.
  - t1..t18: `en_copy` with `index_classifier` 0..17; `end_single_classifier` at t18.
  - t19: `calculate`; `end_tree` also asserted at t19 if `index_tree` = T-1.
  - `index_tree` increments after t19. Next tree, or THR after the last.
- THR, 4 cycles: 3 addresses, with data and `end_all_classifier` during cycles 2..4. Parent/next words are ignored (linear cascade).
- EOD: `end_database` pulse.
- DECIDE: sample `candidate`.
  - 0: `face`=0 → DONE (early reject).
  - 1 and `stage_index` = NUM_STAGES-1: `face`=1 → DONE.
  - Otherwise: `stage_index`+1, `index_tree`=0 → HDR.
- DONE: `done` pulse, → IDLE.
- `start` while `busy` is ignored.
- `reset` low at any state: next edge all registers and outputs are 0, state IDLE. No partial stage resumes.

## Timing
- Stage latency = 20·T + 8 cycles (T=0: 8).
- `done` occurs 1 cycle after the final DECIDE.
- `en_copy`, `calculate`, `end_*` are registered and never overlap except `end_tree` with `calculate`.
- `calculate` is always exactly one cycle after the last `en_copy` of its tree.
- Reset values: all outputs 0, including `rom_addr`, `face`, `busy`.

## Structure
- Shared package `haar_pkg`:
  - state enum
  - NUM_CLASSIFIERS, NUM_STAGE_THRESHOLD, HDR_CYCLES=2, THR_CYCLES=4
  - word-index constants (WEIGHT_1=4, THRESHOLD=15, LEFT=16, RIGHT=17)
- Word-index and tree counters reuse the existing `counter` module: one instance for `index_classifier`, one for `index_tree`.
- FSM and address generation stay in this module.

## Test plan
- Single stage, T=2, candidate=1, NUM_STAGES=1: start at c0 → `calculate` at c22 and c42, `end_database` c47, `done` c49, `face`=1.
- T=0 stage: no `en_copy`/`calculate`, `end_all_classifier` three cycles, stage latency 8.
- 3 stages, T=1, candidate=0 at stage 1 → `done` after 2 stages, `face`=0, `stage_index`=1, no stage-2 ROM reads.
- ROM model returns address as data → `data`=`rom_addr`-1 on every `en_copy` cycle and `index_classifier` runs 0..17 per tree.
- `reset` low at mid-tree word 9 → next cycle all outputs 0; fresh `start` repeats from `rom_addr` 0.
- `start` pulsed during busy and T=300 header → start ignored, tree count clamped to 256.
